// File: rtl/muldiv_issue_pkg.sv
// Shared types and constants for the RV32M multiply/divide issue block.
package muldiv_issue_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned ST_W   = 3;

    // FSM state encoding
    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_START = 3'd1;
    localparam logic [ST_W-1:0] ST_BUSY  = 3'd2;
    localparam logic [ST_W-1:0] ST_WB    = 3'd3;
    localparam logic [ST_W-1:0] ST_DRAIN = 3'd4;

    typedef enum logic [ST_W-1:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        BUSY  = ST_BUSY,
        WB    = ST_WB,
        DRAIN = ST_DRAIN
    } state_e;

    // RV32M funct3 encodings
    localparam logic [F3_W-1:0] F3_MUL    = 3'b000;
    localparam logic [F3_W-1:0] F3_MULH   = 3'b001;
    localparam logic [F3_W-1:0] F3_MULHSU = 3'b010;
    localparam logic [F3_W-1:0] F3_MULHU  = 3'b011;
    localparam logic [F3_W-1:0] F3_DIV    = 3'b100;
    localparam logic [F3_W-1:0] F3_DIVU   = 3'b101;
    localparam logic [F3_W-1:0] F3_REM    = 3'b110;
    localparam logic [F3_W-1:0] F3_REMU   = 3'b111;

    // Operation key: everything that determines the result
    typedef struct packed {
        logic [F3_W-1:0] funct3;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
    } md_req_t;

    // One reuse-cache entry
    typedef struct packed {
        logic            valid;
        md_req_t         key;
        logic [XLEN-1:0] result;
    } cache_entry_t;

endpackage

// File: rtl/muldiv_result_cache.sv
// Single-entry last-result reuse cache: key compare and update.
module muldiv_result_cache
    import muldiv_issue_pkg::*;
#(
    parameter int unsigned REUSE_EN = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  md_req_t         lookup_req,
    output logic            hit_c,
    output logic [XLEN-1:0] hit_result,
    input  logic            wr_en,
    input  md_req_t         wr_req,
    input  logic [XLEN-1:0] wr_result
);

    localparam bit REUSE_ON = (REUSE_EN != 0);

    cache_entry_t entry_q;

    // Entry register, refreshed on every completed operation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry_q <= '0;
        end else if (wr_en) begin
            entry_q.valid  <= 1'b1;
            entry_q.key    <= wr_req;
            entry_q.result <= wr_result;
        end
    end

    // Hit needs a valid entry whose funct3/rs1/rs2 all match
    always_comb begin
        hit_c = REUSE_ON && entry_q.valid && (entry_q.key == lookup_req);
    end

    assign hit_result = entry_q.result;

endmodule

// File: rtl/muldiv_issue.sv
// RV32M issue block: accepts a decode request, drives the MUL/DIV unit,
// waits for completion and writes back; short-circuits repeats via the cache.
module muldiv_issue
    import muldiv_issue_pkg::*;
#(
    parameter int unsigned REUSE_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [F3_W-1:0]   id_funct3,
    input  logic [XLEN-1:0]   id_rs1,
    input  logic [XLEN-1:0]   id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              flush,
    output logic              id_stall,
    output logic              md_start,
    output logic [XLEN-1:0]   md_A,
    output logic [XLEN-1:0]   md_B,
    output logic [OP_W-1:0]   md_op_mul,
    output logic [OP_W-1:0]   md_op_div,
    output logic              md_sel,
    input  logic [XLEN-1:0]   md_R,
    input  logic              md_done,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data
);

    state_e            state_q;
    state_e            state_d;
    md_req_t           op_q;
    md_req_t           id_req_c;
    logic [REG_AW-1:0] rd_q;
    logic [XLEN-1:0]   result_q;
    logic              start_q;
    logic              wb_q;

    logic              accept_c;
    logic              cache_wr_c;
    logic              res_from_unit_c;
    logic              res_from_cache_c;
    logic              hit_c;
    logic [XLEN-1:0]   hit_result;

    assign id_req_c.funct3 = id_funct3;
    assign id_req_c.rs1    = id_rs1;
    assign id_req_c.rs2    = id_rs2;

    muldiv_result_cache #(
        .REUSE_EN (REUSE_EN)
    ) u_cache (
        .clk        (clk),
        .reset      (reset),
        .lookup_req (id_req_c),
        .hit_c      (hit_c),
        .hit_result (hit_result),
        .wr_en      (cache_wr_c),
        .wr_req     (op_q),
        .wr_result  (md_R)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d          = state_q;
        accept_c         = 1'b0;
        cache_wr_c       = 1'b0;
        res_from_unit_c  = 1'b0;
        res_from_cache_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (id_valid && !flush) begin
                    accept_c = 1'b1;
                    if (hit_c) begin
                        res_from_cache_c = 1'b1;
                        state_d          = WB;
                    end else begin
                        state_d = START;
                    end
                end
            end
            START: begin
                // The unit cannot finish in its start cycle; md_done is ignored here
                state_d = flush ? DRAIN : BUSY;
            end
            BUSY: begin
                if (md_done) begin
                    cache_wr_c = 1'b1;
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        res_from_unit_c = 1'b1;
                        state_d         = WB;
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            DRAIN: begin
                // Killed op still completes so the unit is free and the cache stays useful
                if (md_done) begin
                    cache_wr_c = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand and destination registers, loaded on accept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q <= '0;
            rd_q <= '0;
        end else if (accept_c) begin
            op_q <= id_req_c;
            rd_q <= id_rd;
        end
    end

    // Result register, from the unit or from a cache hit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
        end else if (res_from_unit_c) begin
            result_q <= md_R;
        end else if (res_from_cache_c) begin
            result_q <= hit_result;
        end
    end

    // Registered one-cycle strobes for START and WB
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_q <= 1'b0;
            wb_q    <= 1'b0;
        end else begin
            start_q <= (state_d == START);
            wb_q    <= (state_d == WB);
        end
    end

    assign md_start  = start_q;
    assign md_A      = op_q.rs1;
    assign md_B      = op_q.rs2;
    assign md_op_mul = op_q.funct3[OP_W-1:0];
    assign md_op_div = op_q.funct3[OP_W-1:0];
    assign md_sel    = op_q.funct3[F3_W-1];
    assign wb_rd     = rd_q;
    assign wb_data   = result_q;

    // A late flush in the writeback cycle still suppresses the write
    assign wb_valid  = wb_q && !flush;

    // Decode is released only in the writeback cycle; forced low under reset
    assign id_stall  = reset && id_valid && (state_q != WB);

endmodule

// File: doc/muldiv_issue.md
MULDIV_ISSUE -- requirements
Module: muldiv_issue

Interface
REQ-001 The block SHALL have parameter REUSE_EN, default 1, meaning: a nonzero value enables the last-result reuse cache.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports id_valid (input, 1), id_funct3 (input, 3), id_rs1 (input, 32), id_rs2 (input, 32) and id_rd (input, 5): the RV32M request from decode.
REQ-005 The block SHALL have port flush, input, 1 bit: kills the in-flight or requesting instruction.
REQ-006 The block SHALL have port id_stall, output, 1 bit: holds the decode stage.
REQ-007 The block SHALL have ports md_start (output, 1), md_A (output, 32), md_B (output, 32), md_op_mul (output, 2), md_op_div (output, 2) and md_sel (output, 1): drive to the MUL/DIV unit.
REQ-008 The block SHALL have ports md_R (input, 32) and md_done (input, 1): the MUL/DIV unit result.
REQ-009 The block SHALL have ports wb_valid (output, 1), wb_rd (output, 5) and wb_data (output, 32): the writeback.

Function
REQ-010 The FSM SHALL have states IDLE, START, BUSY, WB and DRAIN.
REQ-011 Accept SHALL occur when state=IDLE, id_valid=1 and flush=0, latching funct3, rs1, rs2 and rd into operand registers.
REQ-012 Decode mapping SHALL be: md_sel=funct3[2]; md_op_mul=funct3[1:0]; md_op_div=funct3[1:0] (bit1=REM, bit0=unsigned); md_A=latched rs1; md_B=latched rs2; all registered and stable from START until leaving BUSY/DRAIN.
REQ-013 On a cache miss, accept SHALL transition IDLE->START; md_start SHALL be 1 only in START (exactly one cycle); START SHALL unconditionally transition to BUSY, ignoring md_done.
REQ-014 In BUSY with md_done=1, the block SHALL capture md_R into the result register and the cache, then go to WB; with md_done=0 it SHALL remain in BUSY with no timeout.
REQ-015 In WB: wb_valid=1 for one cycle (wb_valid=0 if flush=1 that cycle); wb_rd=latched rd; wb_data=result; then IDLE.
REQ-016 id_stall SHALL equal id_valid AND state!=WB (combinational); the accepted instruction leaves decode in the WB cycle, so a new accept is possible no earlier than the following IDLE cycle.
REQ-017 Latency SHALL be: accept at T, START at T+1, md_done sampled at cycle D>=T+2, wb_valid at D+1.
REQ-018 Reuse cache SHALL hold {valid, funct3, rs1, rs2, result}; a hit requires REUSE_EN, valid=1, and all three fields equal; on a hit, accept SHALL go IDLE->WB directly (wb_valid at T+1, no md_start).
REQ-019 The cache SHALL be written on every md_done observed in BUSY or DRAIN, including flushed operations.
REQ-020 Flush in START, or in BUSY without md_done, SHALL transition to DRAIN; DRAIN SHALL wait for md_done, update the cache, and then go to IDLE with no writeback.
REQ-021 Flush with md_done in the same BUSY cycle SHALL update the cache, go to IDLE, and produce no writeback.
REQ-022 Flush in IDLE SHALL block accept; in DRAIN, flush SHALL have no additional effect.
REQ-023 rd=0 SHALL be handled as a normal operation (wb_valid asserted; the regfile ignores x0).

Reset
REQ-024 reset=0 SHALL immediately force state IDLE, all outputs 0, operand/result registers 0, and cache valid=0, including mid-operation; the MUL/DIV unit shares the same reset.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding (3-bit localparams) and the RV32M funct3 constants (MUL..REMU).
REQ-026 The reuse cache SHALL be one sub-module, muldiv_result_cache (compare and update); the FSM and datapath SHALL reside in muldiv_issue.

Verification
REQ-027 MUL, rs1=7, rs2=0xFFFFFFFD: md_start exactly at T+1 with md_sel=0, md_op_mul=00; md_done with md_R=0xFFFFFFEB at T+5 -> wb_valid at T+6, wb_data=0xFFFFFFEB; id_stall low only at T+6.
REQ-028 DIVU, rs1=100, rs2=7: md_sel=1, md_op_div=01, operands stable until md_done; md_R=14 -> wb_data=14.
REQ-029 REM 100,7 completing with 2, then an identical REM request: no md_start, wb_valid at T+1, wb_data=2; the same sequence with REUSE_EN=0 restarts the unit.
REQ-030 Flush in BUSY of MULHU 0xFFFFFFFF,0xFFFFFFFF: DRAIN until md_done, no wb_valid, next request held stalled until IDLE; a repeated identical MULHU hits the cache with 0xFFFFFFFE.
REQ-031 Flush coincident with md_done in BUSY -> IDLE, wb_valid never asserted; the cache holds that result.
REQ-032 reset=0 during BUSY: outputs 0 in the same cycle, cache invalid; a following identical request issues md_start.
